// File: rtl/md_unit.sv
// MIPS multiply/divide unit holding architectural HI/LO.
// Latency: MULT/MULTU take MULT_CYCLES and DIV/DIVU take DIV_CYCLES; MTHI/MTLO take effect at the sampling edge.
// Backpressure: busy=1 while an operation runs; requests seen while busy are dropped. Build with MD_CANCEL_EN to honour cancel.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [63:0]    res_q;
    logic [31:0]    hi_q, lo_q;

    logic           cancel_act;
    logic           accept;
    logic           is_mul, is_div, is_signed;
    logic           last_cycle;
    logic           commit;
    logic           abort_run;

`ifdef MD_CANCEL_EN
    assign cancel_act = cancel;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_act    = 1'b0;
`endif

    assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div     = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_signed  = (op == OP_MULT) || (op == OP_DIV);

    // Acceptance is gated by the pre-edge state, so the commit edge never accepts.
    assign accept     = (state_q == S_IDLE) && en && !cancel_act;
    assign last_cycle = (state_q == S_RUN) && (cnt_q == CW'(1));
    assign abort_run  = (state_q == S_RUN) && cancel_act;
    assign commit     = last_cycle && !abort_run;

    // Multiplier: sign-extend for MULT, zero-extend for MULTU, keep the low 64 bits.
    logic [63:0] mul_a, mul_b, mul_p;
    assign mul_a = {{32{is_signed & A[31]}}, A};
    assign mul_b = {{32{is_signed & B[31]}}, B};
    assign mul_p = mul_a * mul_b;

    // Divider works on magnitudes; signs are reapplied afterwards for DIV.
    logic        a_neg, b_neg, q_neg;
    logic [31:0] a_mag, b_mag, uq, ur, quo, rem;
    logic [63:0] div_res;

    assign a_neg = is_signed & A[31];
    assign b_neg = is_signed & B[31];
    assign q_neg = a_neg ^ b_neg;
    assign a_mag = a_neg ? (32'd0 - A) : A;
    assign b_mag = b_neg ? (32'd0 - B) : B;
    assign uq    = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign ur    = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quo   = q_neg ? (32'd0 - uq) : uq;
    assign rem   = a_neg ? (32'd0 - ur) : ur;

    always_comb begin
        div_res = {rem, quo};
        if (B == 32'd0) begin
            div_res = {A, 32'hFFFF_FFFF};
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (is_mul || is_div)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_run || last_cycle) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                if (accept && is_mul) begin
                    cnt_q <= CW'(MULT_CYCLES);
                    res_q <= mul_p;
                end else if (accept && is_div) begin
                    cnt_q <= CW'(DIV_CYCLES);
                    res_q <= div_res;
                end
                if (accept && (op == OP_MTHI)) begin
                    hi_q <= A;
                end
                if (accept && (op == OP_MTLO)) begin
                    lo_q <= A;
                end
            end else begin
                if (abort_run) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
                if (commit) begin
                    hi_q <= res_q[63:32];
                    lo_q <= res_q[31:0];
                end
            end
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == S_RUN);
        HI   = hi_q;
        LO   = lo_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomised self-checking bench for md_unit against an arithmetic reference model.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        cancel;
    logic        busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;
    logic [31:0] hi_m, lo_m;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .A(A), .B(B),
        .cancel(cancel), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (o)
            3'd1: r = sa * sb;
            3'd2: r = ua * ub;
            3'd3: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            3'd4: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    r  = {ur[31:0], uq[31:0]};
                end
            end
            default: r = {hi_m, lo_m};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Zero-latency moves and no-op requests in IDLE.
    task automatic do_simple(input logic [2:0] o, input logic [31:0] a);
        en = 1'b1; op = o; A = a; B = $urandom;
        tick();
        en = 1'b0; op = 3'd0;
        if (o == 3'd5) hi_m = a;
        if (o == 3'd6) lo_m = a;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_hi", HI, hi_m);
        chk("idle_lo", LO, lo_m);
    endtask

    // Multi-cycle op; inj >= 0 presents a stray MTHI/MTLO at that busy cycle.
    task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int inj);
        logic [63:0] r;
        int          n;
        r = ref_result(o, a, b);
        n = (o <= 3'd2) ? MC : DC;
        en = 1'b1; op = o; A = a; B = b;
        tick();
        en = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
        for (int i = 0; i < n; i++) begin
            chk("run_busy", {31'd0, busy}, 32'd1);
            chk("run_hi_hold", HI, hi_m);
            chk("run_lo_hold", LO, lo_m);
            if (i == inj) begin
                en = 1'b1;
                op = 3'(5 + $urandom_range(0, 1));
                A  = $urandom;
            end
            tick();
            en = 1'b0; op = 3'd0;
        end
        hi_m = r[63:32];
        lo_m = r[31:0];
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_hi", HI, hi_m);
        chk("done_lo", LO, lo_m);
    endtask

    initial begin
        logic [2:0] ro;
        reset = 1'b0; en = 1'b0; op = 3'd0; A = '0; B = '0; cancel = 1'b0;
        hi_m = '0; lo_m = '0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Directed cases with hand-derived results.
        run_md(3'd1, 32'hFFFF_FFFD, 32'd5, -1);
        chk("plan_mult_hi", HI, 32'hFFFF_FFFF);
        chk("plan_mult_lo", LO, 32'hFFFF_FFF1);
        run_md(3'd2, 32'hFFFF_FFFD, 32'd5, -1);
        chk("plan_multu_hi", HI, 32'h0000_0004);
        chk("plan_multu_lo", LO, 32'hFFFF_FFF1);
        run_md(3'd4, 32'd100, 32'd7, -1);
        chk("plan_divu_lo", LO, 32'd14);
        chk("plan_divu_hi", HI, 32'd2);
        run_md(3'd3, 32'hFFFF_FFF9, 32'd2, -1);
        chk("plan_div_lo", LO, 32'hFFFF_FFFD);
        chk("plan_div_hi", HI, 32'hFFFF_FFFF);
        run_md(3'd3, 32'h1234_5678, 32'd0, -1);
        chk("plan_div0_lo", LO, 32'hFFFF_FFFF);
        chk("plan_div0_hi", HI, 32'h1234_5678);
        run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("plan_ovf_lo", LO, 32'h8000_0000);
        chk("plan_ovf_hi", HI, 32'd0);
        do_simple(3'd5, 32'hDEAD_BEEF);
        chk("plan_mthi", HI, 32'hDEAD_BEEF);
        run_md(3'd1, 32'd3, 32'd9, 2);
        chk("plan_mt_drop_lo", LO, 32'd27);
        run_md(3'd3, 32'd50, 32'd5, DC - 1);

        // Asynchronous reset in the middle of a divide.
        en = 1'b1; op = 3'd3; A = 32'd1000; B = 32'd3;
        tick();
        en = 1'b0; op = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        hi_m = '0; lo_m = '0;
        tick();
        reset = 1'b1;
        tick();
        run_md(3'd1, 32'd6, 32'd7, -1);
        chk("post_rst_lo", LO, 32'd42);
        chk("post_rst_hi", HI, 32'd0);

        // Cancel mid-run, then cancel on the commit edge.
        do_simple(3'd5, 32'd1);
        do_simple(3'd6, 32'd2);
        en = 1'b1; op = 3'd4; A = 32'd100; B = 32'd7;
        tick();
        en = 1'b0; op = 3'd0;
        for (int i = 0; i < 3; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
`ifdef MD_CANCEL_EN
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hi", HI, 32'd1);
        chk("cancel_lo", LO, 32'd2);
`else
        chk("nocancel_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < DC - 4; i++) tick();
        hi_m = 32'd2; lo_m = 32'd14;
        chk("nocancel_busy_end", {31'd0, busy}, 32'd0);
        chk("nocancel_hi", HI, 32'd2);
        chk("nocancel_lo", LO, 32'd14);
`endif
        en = 1'b1; op = 3'd1; A = 32'd4; B = 32'd4;
        tick();
        en = 1'b0; op = 3'd0;
        for (int i = 0; i < MC - 1; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
`ifndef MD_CANCEL_EN
        hi_m = 32'd0; lo_m = 32'd16;
`endif
        chk("cancel_commit_busy", {31'd0, busy}, 32'd0);
        chk("cancel_commit_hi", HI, hi_m);
        chk("cancel_commit_lo", LO, lo_m);
        en = 1'b1; op = 3'd5; A = 32'hCAFE_0001; cancel = 1'b1;
        tick();
        en = 1'b0; op = 3'd0; cancel = 1'b0;
`ifndef MD_CANCEL_EN
        hi_m = 32'hCAFE_0001;
`endif
        chk("cancel_idle_hi", HI, hi_m);
        chk("cancel_idle_busy", {31'd0, busy}, 32'd0);

        // Random mix of all opcodes.
        for (int k = 0; k < 60; k++) begin
            ro = 3'($urandom_range(0, 7));
            if (ro >= 3'd1 && ro <= 3'd4)
                run_md(ro, rand_opnd(), rand_opnd(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
            else
                do_simple(ro, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
